// File: rtl/l1a_lct_match_gen.sv
// l1a_lct_match_gen: per-channel LCT history ring with a queued L1A window-OR matcher.
module l1a_lct_match_gen #(
  parameter int NCHAN   = 7,
  parameter int DEPTHW  = 7,
  parameter int QDEPTHW = 2,
  parameter int TMR     = 0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               L1A,
  input  logic [NCHAN-1:0]   LCT,
  input  logic [NCHAN-1:0]   CHAN_EN,
  input  logic [DEPTHW-1:0]  L1LATNCY,
  input  logic [3:0]         WINDOW,
  output logic [NCHAN-1:0]   L1A_MATCH,
  output logic               MATCH_VLD,
  output logic               NOMATCH,
  output logic               OVFL,
  output logic [7:0]         DROP_CNT,
  output logic [QDEPTHW:0]   PEND
);
  localparam int DEPTH  = 2**DEPTHW;
  localparam int QDEPTH = 2**QDEPTHW;
  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [DEPTHW-1:0] wp_q, wp_d, rp_q, rp_d, start, age;
  logic [DEPTHW:0] fill_q, fill_d;
  logic [NCHAN-1:0] mem_q [DEPTH];
  logic [NCHAN-1:0] rd_q, rd_d, acc_q, acc_d, match_q, match_d;
  logic [3:0] n_q, n_d, w_in;
  logic vld_q, vld_d, nom_q, nom_d, ovfl_q, ovfl_d;
  logic [7:0] drop_q, drop_d;
  logic [QDEPTHW:0] cnt_q, cnt_d;
  logic [QDEPTHW-1:0] qwr_q, qwr_d, qrd_q, qrd_d;
  logic [DEPTHW-1:0] qs_q [QDEPTH];
  logic [3:0] qw_q [QDEPTH];
  logic full, pop, push, drop, hit;
  if (TMR != 0) begin : g_tmr
  end
  always_comb begin
    w_in   = (WINDOW == 4'd0) ? 4'd1 : WINDOW;
    start  = wp_q - L1LATNCY - DEPTHW'(w_in - 4'd1);
    full   = cnt_q[QDEPTHW];
    pop    = (state_q == IDLE) && (cnt_q != '0);
    push   = L1A && (!full || pop);
    drop   = L1A && full && !pop;
    // entries older than the fill count were written before the last reset
    age    = wp_q - rp_q;
    hit    = (age == '0) ? fill_q[DEPTHW] : ({1'b0, age} <= fill_q);
    wp_d   = wp_q + 1'b1;
    fill_d = fill_q + (DEPTHW+1)'(!fill_q[DEPTHW]);
    qwr_d  = qwr_q + QDEPTHW'(push);
    qrd_d  = qrd_q + QDEPTHW'(pop);
    cnt_d  = cnt_q + (QDEPTHW+1)'(push) - (QDEPTHW+1)'(pop);
    ovfl_d = ovfl_q | drop;
    drop_d = drop_q + 8'(drop && drop_q != 8'hFF);
    rd_d   = (state_q == SCAN && hit) ? mem_q[rp_q] : '0;
    state_d = state_q;
    rp_d    = rp_q;
    n_d     = n_q;
    acc_d   = acc_q | rd_q;
    match_d = match_q;
    vld_d   = 1'b0;
    nom_d   = 1'b0;
    unique case (state_q)
      IDLE: if (pop) begin
        state_d = SCAN;
        rp_d    = qs_q[qrd_q];
        n_d     = qw_q[qrd_q];
        acc_d   = '0;
      end
      SCAN: begin
        rp_d    = rp_q + 1'b1;
        n_d     = n_q - 4'd1;
        state_d = (n_q == 4'd1) ? FLUSH : SCAN;
      end
      FLUSH: begin
        state_d = DONE;
        match_d = acc_q | rd_q;
        vld_d   = 1'b1;
        nom_d   = (acc_q | rd_q) == '0;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      fill_q  <= '0;
      rd_q    <= '0;
      acc_q   <= '0;
      match_q <= '0;
      n_q     <= '0;
      vld_q   <= 1'b0;
      nom_q   <= 1'b0;
      ovfl_q  <= 1'b0;
      drop_q  <= '0;
      cnt_q   <= '0;
      qwr_q   <= '0;
      qrd_q   <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      fill_q  <= fill_d;
      rd_q    <= rd_d;
      acc_q   <= acc_d;
      match_q <= match_d;
      n_q     <= n_d;
      vld_q   <= vld_d;
      nom_q   <= nom_d;
      ovfl_q  <= ovfl_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      qwr_q   <= qwr_d;
      qrd_q   <= qrd_d;
    end
  end
  always_ff @(posedge CLK) begin
    mem_q[wp_q] <= LCT & CHAN_EN;
    if (push) begin
      qs_q[qwr_q] <= start;
      qw_q[qwr_q] <= w_in;
    end
  end
  assign L1A_MATCH = match_q;
  assign MATCH_VLD = vld_q;
  assign NOMATCH   = nom_q;
  assign OVFL      = ovfl_q;
  assign DROP_CNT  = drop_q;
  assign PEND      = cnt_q;
endmodule
